// File: rtl/iob_eth_tx_sched.sv
// Two-requester round-robin scheduler in front of an Ethernet transmitter.
// It checks frame lengths, drives the start/ready handshake, times out stuck starts and enforces the inter-frame gap.
module iob_eth_tx_sched #(
  parameter int IFG_CYCLES = 24,
  parameter int MIN_LEN    = 68,
  parameter int MAX_LEN    = 1526,
  parameter int TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [10:0] len0,
  input  logic [10:0] len1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic        tx_send,
  output logic [10:0] tx_nbytes,
  input  logic        tx_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  // Transmitter handshake: tx_send is a level held until tx_ready is seen low
  // (frame accepted); tx_ready returning high marks the end of the frame.
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           owner_q, owner_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic [1:0]     err_q, err_d;
  logic           busy_q, busy_d;
  logic           tx_send_q, tx_send_d;
  logic [10:0]    tx_nbytes_q, tx_nbytes_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

  logic           sel;
  logic [10:0]    sel_len;
  logic           len_ok;

  // The pointer only arbitrates when both requesters are asking.
  assign sel     = (req == 2'b11) ? ptr_q : req[1];
  assign sel_len = sel ? len1 : len0;
  assign len_ok  = (sel_len >= MIN_L) && (sel_len <= MAX_L);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    err_d       = 2'b00;
    tx_send_d   = tx_send_q;
    tx_nbytes_d = tx_nbytes_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_ready && (req != 2'b00)) begin
          if (!len_ok) begin
            err_d[sel] = 1'b1;
            ptr_d      = ~sel;
          end else begin
            tx_nbytes_d = sel_len;
            gnt_d       = sel ? 2'b10 : 2'b01;
            owner_d     = sel;
            tx_send_d   = 1'b1;
            to_cnt_d    = '0;
            state_d     = SEND;
          end
        end
      end
      SEND: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          state_d   = WAIT_DONE;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          tx_send_d       = 1'b0;
          gnt_d           = 2'b00;
          err_d[owner_q]  = 1'b1;
          ptr_d           = ~owner_q;
          if (IFG_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GW'(IFG_CYCLES - 1);
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          done_d[owner_q] = 1'b1;
          gnt_d           = 2'b00;
          ptr_d           = ~owner_q;
          if (IFG_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GW'(IFG_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      busy_q      <= 1'b0;
      tx_send_q   <= 1'b0;
      tx_nbytes_q <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      tx_send_q   <= tx_send_d;
      tx_nbytes_q <= tx_nbytes_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign tx_send   = tx_send_q;
  assign tx_nbytes = tx_nbytes_q;

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Bench for iob_eth_tx_sched: directed scenarios plus randomized frame mixes,
// checked against a transaction-level arbitration model and a transmitter model.
module tb_iob_eth_tx_sched;

  localparam int IFG     = 24;
  localparam int MIN_LEN = 68;
  localparam int MAX_LEN = 1526;
  localparam int TO      = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req, gnt, done, err;
  logic [10:0] len0, len1, tx_nbytes;
  logic        busy, tx_send, tx_ready;

  logic [1:0]  req_b, gnt_b, done_b, err_b;
  logic [10:0] len0_b, len1_b, tx_nbytes_b;
  logic        busy_b, tx_send_b, tx_ready_b;

  iob_eth_tx_sched #(.IFG_CYCLES(IFG), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .tx_send(tx_send), .tx_nbytes(tx_nbytes), .tx_ready(tx_ready));

  iob_eth_tx_sched #(.IFG_CYCLES(0), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .len0(len0_b), .len1(len1_b), .gnt(gnt_b), .done(done_b),
    .err(err_b), .busy(busy_b), .tx_send(tx_send_b), .tx_nbytes(tx_nbytes_b), .tx_ready(tx_ready_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // scoreboard: {kind (1=err), requester, length}
  logic [12:0] exp_q[$];
  logic [10:0] lq0[$], lq1[$];
  logic [1:0]  gnt_log[$];
  bit          mptr = 1'b0;

  bit never_drop = 1'b0, drop_mid = 1'b0, rand_tx = 1'b0;
  int drop_delay = 2, hold_len = 220, seen = 0, low_cnt = 0;
  logic [1:0]  prev_gnt = 2'b00;
  logic        prev_busy = 1'b0;
  logic [10:0] frame_len = '0;
  int send_cnt = 0, last_send_cnt = 0, last_end_cyc = -1000, last_done_cyc = 0, busy_fall_cyc = 0;
  int n_gnt_scn = 0, n_send_scn = 0;
  logic busy_at_end = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Arbitration model: pointer favours the other requester after each outcome.
  task automatic build_exp(input bit timeout_mode);
    int i0 = 0;
    int i1 = 0;
    bit s;
    logic [10:0] l;
    bit bad;
    while (i0 < lq0.size() || i1 < lq1.size()) begin
      if (i0 < lq0.size() && i1 < lq1.size()) s = mptr;
      else s = (i1 < lq1.size());
      l = s ? lq1[i1] : lq0[i0];
      bad = (int'(l) < MIN_LEN) || (int'(l) > MAX_LEN);
      exp_q.push_back({bad || timeout_mode, s, l});
      mptr = !s;
      if (s) i1++; else i0++;
    end
  endtask

  // One clock: sample outputs, score events, then drive transmitter and requesters.
  task automatic tick();
    logic [12:0] e;
    @(posedge clk);
    #1;
    cyc++;
    chk("pulse_excl", 32'({$onehot0(done), $onehot0(err), !((|done) && (|err)), $onehot0(gnt)}), 32'hF);
    if (!rst) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        n_gnt_scn++;
        gnt_log.push_back(gnt);
        send_cnt = 0;
        chk("gnt_spacing", 32'((cyc - last_end_cyc) >= IFG + 1), 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          frame_len = e[10:0];
          chk("gnt_id", 32'(gnt), e[11] ? 32'd2 : 32'd1);
          chk("tx_nbytes", 32'(tx_nbytes), 32'(e[10:0]));
        end else begin
          chk("gnt_unexpected", 32'(gnt), 0);
        end
      end
      if (gnt != 2'b00 && prev_gnt != 2'b00) chk("nbytes_hold", 32'(tx_nbytes), 32'(frame_len));
      if (tx_send) begin
        send_cnt++;
        n_send_scn++;
      end
      if (done != 2'b00 || err != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({done, err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome", 32'({|err, err[1] | done[1]}), 32'({e[12], e[11]}));
          if (e[11]) lq1.delete(0); else lq0.delete(0);
        end
        if (prev_gnt != 2'b00) begin
          last_end_cyc = cyc;
          last_send_cnt = send_cnt;
          busy_at_end = busy;
        end
        if (|done) last_done_cyc = cyc;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
    end
    prev_gnt = gnt;
    prev_busy = busy;
    // transmitter model
    if (rst) begin
      tx_ready = 1'b1;
      seen = 0;
      low_cnt = 0;
    end else if (!tx_ready) begin
      low_cnt--;
      if (low_cnt <= 0) tx_ready = 1'b1;
    end else if (tx_send) begin
      seen++;
      if (!never_drop && seen == drop_delay + 1) begin
        tx_ready = 1'b0;
        low_cnt = hold_len;
        seen = 0;
        if (rand_tx) begin
          drop_delay = $urandom_range(0, 5);
          hold_len = $urandom_range(1, 30);
        end
      end
    end else begin
      seen = 0;
    end
    // requesters
    req[0] = (lq0.size() > 0) && !(drop_mid && gnt[0]);
    req[1] = (lq1.size() > 0) && !(drop_mid && gnt[1]);
    len0 = (gnt != 2'b00 || lq0.size() == 0) ? 11'($urandom) : lq0[0];
    len1 = (gnt != 2'b00 || lq1.size() == 0) ? 11'($urandom) : lq1[0];
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("run_budget", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lq0.delete();
    lq1.delete();
    exp_q.delete();
    mptr = 1'b0;
    last_end_cyc = -1000;
    tick();
    tick();
    chk("rst_ctrl", 32'({gnt, done, err, busy, tx_send}), 0);
    chk("rst_nbytes", 32'(tx_nbytes), 0);
    chk("rst_ctrl_b", 32'({gnt_b, done_b, err_b, busy_b, tx_send_b}), 0);
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [10:0] rand_len();
    int r;
    int pick;
    logic [10:0] v;
    r = $urandom_range(0, 7);
    pick = $urandom_range(0, 3);
    if (r == 0) v = 11'($urandom_range(0, MIN_LEN - 1));
    else if (r == 1) v = 11'($urandom_range(MAX_LEN + 1, 2047));
    else if (r == 2) v = (pick == 0) ? 11'(MIN_LEN - 1) : (pick == 1) ? 11'(MIN_LEN) :
                         (pick == 2) ? 11'(MAX_LEN) : 11'(MAX_LEN + 1);
    else v = 11'($urandom_range(MIN_LEN, MAX_LEN));
    return v;
  endfunction

  initial begin
    logic [1:0] b_exp[3];
    int b_idx;
    int last_done_b;
    int pb0, pb1, low_b, n;
    logic [1:0] prev_gnt_b;
    b_exp[0] = 2'b01;
    b_exp[1] = 2'b10;
    b_exp[2] = 2'b01;
    rst = 1'b1;
    req = 2'b00; len0 = '0; len1 = '0; tx_ready = 1'b1;
    req_b = 2'b00; len0_b = 11'd100; len1_b = 11'd100; tx_ready_b = 1'b1;

    // reset state
    do_reset();

    // single frame
    drop_delay = 2; hold_len = 220; n_gnt_scn = 0;
    lq0.push_back(11'd100);
    build_exp(1'b0);
    run(600);
    chk("single_frames", 32'(n_gnt_scn), 1);
    chk("single_send_cycles", 32'(last_send_cnt), 3);
    chk("single_ifg_busy", 32'(busy_fall_cyc - last_done_cyc), IFG);

    // contention, starting from a fresh pointer
    do_reset();
    gnt_log.delete();
    lq0.push_back(11'd100); lq0.push_back(11'd100); lq1.push_back(11'd100);
    build_exp(1'b0);
    run(2000);
    chk("cont_count", 32'(gnt_log.size()), 3);
    if (gnt_log.size() == 3) begin
      chk("cont_g0", 32'(gnt_log[0]), 1);
      chk("cont_g1", 32'(gnt_log[1]), 2);
      chk("cont_g2", 32'(gnt_log[2]), 1);
    end

    // bad length on requester 1, then check the pointer favours requester 0
    hold_len = 20; n_gnt_scn = 0; n_send_scn = 0;
    lq1.push_back(11'd20);
    build_exp(1'b0);
    run(50);
    chk("bad_no_gnt", 32'(n_gnt_scn), 0);
    chk("bad_no_send", 32'(n_send_scn), 0);
    gnt_log.delete();
    lq0.push_back(11'd100); lq1.push_back(11'd100);
    build_exp(1'b0);
    run(500);
    chk("bad_then_ptr0", 32'(gnt_log.size() > 0 ? gnt_log[0] : 2'b00), 1);

    // transmitter never accepts
    never_drop = 1'b1;
    lq0.push_back(11'd200);
    build_exp(1'b1);
    run(200);
    chk("timeout_send_cycles", 32'(last_send_cnt), TO);
    chk("timeout_gap_busy", 32'(busy_at_end), 1);
    never_drop = 1'b0;

    // randomized frame mixes
    rand_tx = 1'b1;
    for (int round = 0; round < 5; round++) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) lq0.push_back(rand_len());
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) lq1.push_back(rand_len());
      build_exp(1'b0);
      run(3000);
    end
    rand_tx = 1'b0;

    // reset while waiting for frame end
    drop_delay = 1; hold_len = 220;
    lq0.push_back(11'd300);
    build_exp(1'b0);
    n = 0;
    while (!(gnt != 2'b00 && !tx_send) && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_reached_wait", 32'(gnt != 2'b00 && !tx_send), 1);
    repeat (3) tick();
    rst = 1'b1;
    lq0.delete(); lq1.delete(); exp_q.delete();
    mptr = 1'b0;
    last_end_cyc = -1000;
    tick();
    chk("midrst_outputs", 32'({gnt, done, err, busy, tx_send}), 0);
    chk("midrst_nbytes", 32'(tx_nbytes), 0);
    rst = 1'b0;
    tick();
    chk("midrst_no_done", 32'({done, err}), 0);

    // requester drops req mid-frame
    hold_len = 15; drop_mid = 1'b1;
    lq0.push_back(11'd100);
    build_exp(1'b0);
    run(300);
    drop_mid = 1'b0;

    // zero-gap build: back-to-back frames
    pb0 = 2; pb1 = 1; b_idx = 0; last_done_b = -1; low_b = 0; prev_gnt_b = 2'b00;
    n = 0;
    while ((b_idx < 3 || pb0 + pb1 > 0) && n < 300) begin
      tick();
      n++;
      if (gnt_b != 2'b00 && prev_gnt_b == 2'b00) begin
        if (b_idx < 3) chk("b_gnt_order", 32'(gnt_b), 32'(b_exp[b_idx]));
        if (last_done_b >= 0) chk("b_back_to_back", 32'(cyc - last_done_b), 1);
        b_idx++;
      end
      if (|done_b) begin
        last_done_b = cyc;
        if (done_b[0]) pb0--; else pb1--;
      end
      prev_gnt_b = gnt_b;
      if (!tx_ready_b) begin
        low_b--;
        if (low_b <= 0) tx_ready_b = 1'b1;
      end else if (tx_send_b) begin
        tx_ready_b = 1'b0;
        low_b = 4;
      end
      req_b = {pb1 > 0, pb0 > 0};
    end
    chk("b_grants", 32'(b_idx), 3);
    chk("b_pending", 32'(pb0 + pb1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
